// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding, default target address, byte width.
// Used by both the target and the initiator.
package i2c_pkg;

  localparam int         BYTE_W       = 8;
  localparam logic [6:0] DEFAULT_ADDR = 7'h1E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR,
    ST_WR_ACK,
    ST_RD,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizes one I2C line into i2c_clk and flags its edges.
// Latency: SYNC_STAGES cycles to level, edge pulses one cycle wide; no backpressure.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i2c_clk,
  input  logic i_reset_n,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Bus lines idle high; resetting to 1 avoids a phantom edge on a quiet bus.
  always_ff @(posedge i2c_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: oversampled START/STOP/address decode, ACK, byte delivery and supply; never stretches SCL.
// Latency: SDA changes one cycle after the synchronized SCL fall; no backpressure (local logic must keep pace).
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR        = DEFAULT_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              i2c_clk,
  input  logic              i_reset_n,
  inout  wire               io_sda,
  input  logic              i_scl,
  input  logic [BYTE_W-1:0] i_tx_data,
  output logic              o_tx_load,
  output logic [BYTE_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_busy
);

  localparam logic [2:0] CNT_LAST = 3'(BYTE_W - 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_state_t        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [BYTE_W-2:0] shreg_q, shreg_d;
  logic              sda_oe_q, sda_oe_d;
  logic              rw_q, rw_d;
  logic [BYTE_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_load_q, tx_load_d;
  logic [BYTE_W-1:0] shift_in;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .i2c_clk(i2c_clk), .i_reset_n(i_reset_n), .line(i_scl),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .i2c_clk(i2c_clk), .i_reset_n(i_reset_n), .line(io_sda),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    sda_oe_d   = sda_oe_q;
    rw_d       = rw_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    shift_in   = {shreg_q, sda_lvl};

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      cnt_d    = 3'd0;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      sda_oe_d = 1'b0;
      cnt_d    = CNT_LAST;
    end else begin
      case (state_q)
        ST_ADDR: if (scl_rise) begin
          shreg_d = shift_in[BYTE_W-2:0];
          cnt_d   = cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            rw_d    = sda_lvl;
            // shreg_q holds the seven address bits; general call is never claimed.
            state_d = (shreg_q == ADDR && shreg_q != 7'd0) ? ST_ADDR_ACK : ST_WAIT_STOP;
          end
        end
        ST_ADDR_ACK, ST_WR_ACK, ST_RD_ACK: begin
          // The first fall in an ACK slot starts our drive; the second closes the slot.
          if (state_q == ST_RD_ACK && scl_rise && sda_lvl) begin
            state_d = ST_WAIT_STOP;
          end else if (scl_fall && state_q != ST_RD_ACK && !sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (scl_fall && state_q != ST_RD_ACK && !(state_q == ST_ADDR_ACK && rw_q)) begin
            sda_oe_d = 1'b0;
            state_d  = ST_WR;
            cnt_d    = CNT_LAST;
          end else if (scl_fall) begin
            shreg_d   = i_tx_data[BYTE_W-2:0];
            sda_oe_d  = ~i_tx_data[BYTE_W-1];
            tx_load_d = 1'b1;
            cnt_d     = CNT_LAST;
            state_d   = ST_RD;
          end
        end
        ST_WR: if (scl_rise) begin
          shreg_d = shift_in[BYTE_W-2:0];
          cnt_d   = cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            rx_data_d  = shift_in;
            rx_valid_d = 1'b1;
            state_d    = ST_WR_ACK;
          end
        end
        ST_RD: if (scl_fall) begin
          if (cnt_q == 3'd0) begin
            sda_oe_d = 1'b0;
            state_d  = ST_RD_ACK;
          end else begin
            sda_oe_d = ~shreg_q[BYTE_W-2];
            shreg_d  = {shreg_q[BYTE_W-3:0], 1'b0};
            cnt_d    = cnt_q - 3'd1;
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i2c_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      shreg_q    <= '0;
      sda_oe_q   <= 1'b0;
      rw_q       <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      sda_oe_q   <= sda_oe_d;
      rw_q       <= rw_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
    end
  end

  assign io_sda     = sda_oe_q ? 1'b0 : 1'bz;
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_tx_load  = tx_load_q;
  assign o_busy     = state_q inside {ST_ADDR_ACK, ST_WR, ST_WR_ACK, ST_RD, ST_RD_ACK};

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) for the open-drain SCL/SDA bus driven by our I2C initiator.
- Lets the MIPSfpga side act as a bus device, e.g. for a compass emulator or for loopback verification of the initiator.
- Oversamples SCL/SDA on its own i2c_clk, decodes START/STOP, matches a 7-bit address, ACKs, and delivers written bytes to local logic.
- Supplies read bytes from local logic. Never stretches SCL.

Parameters:
- ADDR, 7'h1E, 7-bit target address compared against the first byte after START.
- SYNC_STAGES, 2, synchronizer depth for SCL and SDA, minimum 2.

Ports:
- i2c_clk  input  1  oversampling clock; must be at least 8x the SCL frequency.
- i_reset_n  input  1  reset.
- io_sda  inout  1  open-drain SDA; the block drives only 0 or z.
- i_scl  input  1  SCL from the bus, observed only.
- i_tx_data  input  8  next byte returned to the initiator on a read.
- o_tx_load  output  1  one-cycle pulse when i_tx_data is captured; local logic advances to the next byte.
- o_rx_data  output  8  last byte written by the initiator.
- o_rx_valid  output  1  one-cycle pulse when o_rx_data updates.
- o_busy  output  1  high while addressed; low otherwise.

Behaviour:
- Reset is asynchronous, active-low; clock is i2c_clk. The block samples i_reset_n asynchronously.
- Reset values: SDA released (z), o_rx_data=0, o_rx_valid=0, o_tx_load=0, o_busy=0, state IDLE, bit counter 0.
- Input path: SCL and SDA pass through SYNC_STAGES flops, then a history flop.
  - scl_rise = prev 0 and now 1; scl_fall = prev 1 and now 0.
  - START = SDA falls while synced SCL is high.
  - STOP = SDA rises while synced SCL is high.
- Byte order: all bytes MSB first. Data is sampled on scl_rise; the block changes SDA only on the i2c_clk cycle after scl_fall.
- States: IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP.
- IDLE: SDA released. START -> ADDR with bit counter 7.
- ADDR:
  - Shift 8 bits on scl_rise.
  - On the 8th rise, if bits[7:1]==ADDR, then ADDR_ACK; otherwise WAIT_STOP. A mismatch never drives SDA.
- ADDR_ACK:
  - On scl_fall, drive SDA low.
  - On the next scl_fall (end of the 9th clock), continue by R/W bit:
    - R/W=0: release SDA -> WR.
    - R/W=1: capture i_tx_data, pulse o_tx_load, drive bit 7 -> RD.
  - o_busy rises when ADDR_ACK is entered.
- WR:
  - Shift 8 bits.
  - On the 8th scl_rise, update o_rx_data and pulse o_rx_valid in the same cycle -> WR_ACK.
- WR_ACK: drive low on scl_fall, release on the following scl_fall -> WR.
- RD:
  - Shift register output drives SDA low for 0 and z for 1, updated on each scl_fall.
  - After the 8th bit's scl_fall, release SDA -> RD_ACK.
- RD_ACK: sample SDA on scl_rise.
  - 0 (ACK): on scl_fall, capture i_tx_data, pulse o_tx_load, drive bit 7 -> RD.
  - 1 (NACK): -> WAIT_STOP.
- WAIT_STOP: SDA released; o_busy=0; waits for START (-> ADDR) or STOP (-> IDLE).
- Global priority, highest first: reset, STOP, START, then state logic.
  - STOP in any state -> IDLE, release SDA, o_busy=0.
  - START (repeated) in any state -> ADDR, release SDA, o_busy=0, counter 7. A partially received write byte is discarded with no o_rx_valid.
- Mid-transfer reset releases SDA within the same assertion, asynchronously.
- A general-call address (0x00) is not acknowledged.

Decomposition:
- Shared package i2c_pkg: state encodings, default target address, and the 8-bit byte width constant, shared with the initiator.
- One sub-module i2c_sync_edge (one instance per line):
  - parameter SYNC_STAGES
  - synchronizes one line; outputs level, rise, fall.
- START/STOP detection is done in the parent from the two instances.

Test Plan:
- Write: START, 0x3C, 0x02, 0x00, STOP -> ACK on all three 9th clocks; o_rx_valid pulses twice with o_rx_data 0x02 then 0x00; o_busy high from the address ACK until STOP.
- Read: START, 0x3D, i_tx_data 0xA5 then 0x5A, initiator ACK then NACK, STOP -> bus shows 0xA5, 0x5A; o_tx_load pulses exactly twice; SDA released after the NACK.
- Address miss: START, 0x3A, 0x55, STOP -> SDA never driven low; no o_rx_valid or o_tx_load; o_busy stays 0.
- Repeated START: write 0x3C, 0x03, then repeated START, 0x3D, NACK, STOP -> one o_rx_valid (0x03); read phase returns i_tx_data; the state enters ADDR at the repeated START.
- Abort: STOP after 4 bits of a write byte -> no o_rx_valid, IDLE. Separately, assert i_reset_n low while driving a 0 bit in RD -> io_sda z immediately, all outputs at reset values.
- Oversampling limit: i2c_clk at exactly 8x SCL, 16-byte write burst -> all bytes received correctly, every ACK present.
